// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  // Arbiter FSM: IDLE arbitrates, SEND waits for an accept, SETTLE masks TXRDY
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    SETTLE = 2'd2
  } arb_state_e;

  // One counter width serves both the settle window and the stall timer
  function automatic int cnt_width(input int stall_timeout, input int settle_cyc);
    int mx;
    mx = (stall_timeout > settle_cyc) ? stall_timeout : settle_cyc;
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request strictly after
// last_owner, wrapping around, so last_owner itself has lowest priority.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx,
  output logic            any
);

  logic found;
  int   cand;

  // Walk the ring starting one past the previous owner
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = 0;
    any      = |req;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_owner) + k) % NREQ;
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = IW'(cand);
      end
    end
    if (found) pick[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one CoreUART-style transmitter
// among NREQ byte-stream requesters. A grant is held until a byte marked
// last has been written, or until the owner stalls past STALL_TIMEOUT.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ          = 3,
  parameter int SETTLE_CYC    = 2,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NREQ-1:0]        REQ_VALID,
  input  logic [BYTE_W*NREQ-1:0] REQ_DATA,
  input  logic [NREQ-1:0]        REQ_LAST,
  output logic [NREQ-1:0]        REQ_READY,
  output logic [NREQ-1:0]        GRANT,
  input  logic                   UART_TXRDY,
  output logic                   UART_WEN_N,
  output logic [BYTE_W-1:0]      UART_DATA,
  output logic                   BUSY,
  output logic                   TIMEOUT_ERR
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_width(STALL_TIMEOUT, SETTLE_CYC);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC);
  localparam logic [CW-1:0] STALL_LIM = CW'(STALL_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Lane view of the flat data bus: lane i is bits [8i+7:8i]
  logic [NREQ-1:0][BYTE_W-1:0] lane_data;
  assign lane_data = REQ_DATA;

  arb_state_e          state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [IW-1:0]       own_q, own_d;      // index of current owner
  logic [IW-1:0]       last_q, last_d;    // round-robin pointer
  logic [CW-1:0]       settle_q, settle_d;
  logic [CW-1:0]       stall_q, stall_d;
  logic                lflag_q, lflag_d;  // last flag of byte in flight
  logic                wen_n_q, wen_n_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                tout_q, tout_d;

  logic [NREQ-1:0]     pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  logic                own_valid;
  logic                own_last;
  logic [BYTE_W-1:0]   own_data;
  logic                send_rdy;
  logic                accept;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (REQ_VALID),
    .last_owner (last_q),
    .pick       (pick_oh),
    .pick_idx   (pick_idx),
    .any        (pick_any)
  );

  // Owner-side view of the request bus
  assign own_valid = REQ_VALID[own_q];
  assign own_last  = REQ_LAST[own_q];
  assign own_data  = lane_data[own_q];

  // Ready is combinational from TXRDY so an accept costs no extra cycle
  assign send_rdy  = (state_q == SEND) && UART_TXRDY;
  assign accept    = send_rdy && own_valid;
  assign REQ_READY = send_rdy ? grant_q : '0;

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    own_d    = own_q;
    last_d   = last_q;
    settle_d = settle_q;
    stall_d  = stall_q;
    lflag_d  = lflag_q;
    wen_n_d  = 1'b1;
    data_d   = data_q;
    tout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = SEND;
          grant_d = pick_oh;
          own_d   = pick_idx;
          stall_d = '0;
        end
      end
      SEND: begin
        if (accept) begin
          wen_n_d  = 1'b0;
          data_d   = own_data;
          lflag_d  = own_last;
          settle_d = SETTLE_LD;
          stall_d  = '0;
          state_d  = SETTLE;
        end else if (!own_valid && (STALL_TIMEOUT != 0)) begin
          // Only an absent byte counts as a stall; TXRDY low is backpressure
          if (stall_q == STALL_LIM - CNT_ONE) begin
            tout_d  = 1'b1;
            grant_d = '0;
            last_d  = own_q;
            stall_d = '0;
            state_d = IDLE;
          end else begin
            stall_d = stall_q + CNT_ONE;
          end
        end
      end
      SETTLE: begin
        // TXRDY is not looked at here: the UART may not have dropped it yet
        if (settle_q <= CNT_ONE) begin
          settle_d = '0;
          if (lflag_q) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = own_q;
          end else begin
            state_d = SEND;
          end
        end else begin
          settle_d = settle_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register; reset abandons any frame in flight
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      own_q    <= '0;
      last_q   <= IW'(NREQ - 1);
      settle_q <= '0;
      stall_q  <= '0;
      lflag_q  <= 1'b0;
      wen_n_q  <= 1'b1;
      data_q   <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      own_q    <= own_d;
      last_q   <= last_d;
      settle_q <= settle_d;
      stall_q  <= stall_d;
      lflag_q  <= lflag_d;
      wen_n_q  <= wen_n_d;
      data_q   <= data_d;
      tout_q   <= tout_d;
    end
  end

  assign GRANT       = grant_q;
  assign UART_WEN_N  = wen_n_q;
  assign UART_DATA   = data_q;
  assign BUSY        = (state_q != IDLE);
  assign TIMEOUT_ERR = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter with a transaction-level
// reference: each requester is a byte queue, the model tracks who owns the
// UART, how long until it may send again, and how long it has been silent.
module tb_uart_tx_arbiter;

  localparam int NREQ   = 3;
  localparam int SETTLE = 2;
  localparam int STO    = 16;

  logic                CLK = 1'b0;
  logic                RESET_N;
  logic [NREQ-1:0]     REQ_VALID, REQ_LAST, REQ_READY, GRANT;
  logic [8*NREQ-1:0]   REQ_DATA;
  logic                UART_TXRDY, UART_WEN_N, BUSY, TIMEOUT_ERR;
  logic [7:0]          UART_DATA;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(
    .NREQ          (NREQ),
    .SETTLE_CYC    (SETTLE),
    .STALL_TIMEOUT (STO)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .REQ_VALID   (REQ_VALID),
    .REQ_DATA    (REQ_DATA),
    .REQ_LAST    (REQ_LAST),
    .REQ_READY   (REQ_READY),
    .GRANT       (GRANT),
    .UART_TXRDY  (UART_TXRDY),
    .UART_WEN_N  (UART_WEN_N),
    .UART_DATA   (UART_DATA),
    .BUSY        (BUSY),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // sources: {last, data} per byte
  logic [8:0] src_q [NREQ][$];
  int         hold_cnt [NREQ];
  int         drop_pct = 0;
  int         rdy_pct  = 100;

  // reference model
  int         m_owner, m_gap, m_stall, m_last_owner;
  bit         m_pend_last, m_wen, m_tout;
  logic [7:0] m_data;

  // observation logs
  int         wen_log[$], wen_cyc[$], grant_log[$], tout_cyc[$];
  logic [NREQ-1:0] prev_grant;
  int         exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_log(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    if (got.size() == exp.size())
      for (int i = 0; i < exp.size(); i++) chk(name, got[i], exp[i]);
  endtask

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_stall = 0; m_last_owner = NREQ - 1;
    m_pend_last = 0; m_wen = 0; m_tout = 0; m_data = 8'h00;
  endtask

  // Advance the model across one rising edge with the inputs now applied
  task automatic model_step();
    bit nw, nt;
    nw = 0; nt = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last_owner + k) % NREQ;
        if (REQ_VALID[c]) begin m_owner = c; break; end
      end
      m_gap = 0; m_stall = 0;
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0 && m_pend_last) begin m_last_owner = m_owner; m_owner = -1; end
    end else if (REQ_VALID[m_owner] && UART_TXRDY) begin
      nw = 1;
      m_data = REQ_DATA[8*m_owner +: 8];
      m_pend_last = REQ_LAST[m_owner];
      m_gap = SETTLE; m_stall = 0;
      void'(src_q[m_owner].pop_front());
    end else if (!REQ_VALID[m_owner]) begin
      m_stall++;
      if (m_stall >= STO) begin nt = 1; m_last_owner = m_owner; m_owner = -1; end
    end
    m_wen = nw; m_tout = nt;
  endtask

  task automatic compare();
    logic [NREQ-1:0] eg, er;
    eg = '0; er = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (m_gap == 0 && UART_TXRDY) er[m_owner] = 1'b1;
    end
    chk("grant", GRANT, eg);
    chk("ready", REQ_READY, er);
    chk("wen_n", UART_WEN_N, !m_wen);
    chk("data", UART_DATA, m_data);
    chk("busy", BUSY, m_owner >= 0);
    chk("timeout", TIMEOUT_ERR, m_tout);
  endtask

  // One clock: drive at the falling edge, check, log, then step the model
  task automatic step();
    @(negedge CLK);
    cyc++;
    UART_TXRDY = ($urandom_range(99) < rdy_pct);
    for (int i = 0; i < NREQ; i++) begin
      bit v;
      if (hold_cnt[i] > 0) hold_cnt[i]--;
      v = (src_q[i].size() != 0) && (hold_cnt[i] == 0) && ($urandom_range(99) >= drop_pct);
      REQ_VALID[i] = v;
      REQ_DATA[8*i +: 8] = v ? src_q[i][0][7:0] : 8'($urandom);
      REQ_LAST[i] = v ? src_q[i][0][8] : 1'($urandom);
    end
    #1;
    compare();
    if (!UART_WEN_N) begin wen_log.push_back(int'(UART_DATA)); wen_cyc.push_back(cyc); end
    if (TIMEOUT_ERR) tout_cyc.push_back(cyc);
    if (prev_grant == '0 && GRANT != '0)
      for (int i = 0; i < NREQ; i++) if (GRANT[i]) grant_log.push_back(i);
    prev_grant = GRANT;
    model_step();
  endtask

  function automatic bit drained();
    bit e;
    e = (m_owner < 0);
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) e = 0;
    return e;
  endfunction

  task automatic run_drain(input string name, input int max);
    int k;
    k = 0;
    while (!drained() && k < max) begin step(); k++; end
    chk({name, "_drain"}, drained(), 1);
    repeat (2) step();
  endtask

  task automatic run_until_wen(input string name, input int n, input int max);
    int k;
    k = 0;
    while (wen_log.size() < n && k < max) begin step(); k++; end
    chk({name, "_wait"}, wen_log.size() >= n, 1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    REQ_VALID = '0; REQ_LAST = '0; REQ_DATA = '0; UART_TXRDY = 1'b0;
    for (int i = 0; i < NREQ; i++) begin src_q[i].delete(); hold_cnt[i] = 0; end
    model_reset();
    #1;
    chk("rst_grant", GRANT, 0);
    chk("rst_ready", REQ_READY, 0);
    chk("rst_wen_n", UART_WEN_N, 1);
    chk("rst_data", UART_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_timeout", TIMEOUT_ERR, 0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    wen_log.delete(); wen_cyc.delete(); grant_log.delete(); tout_cyc.delete();
    prev_grant = '0; drop_pct = 0; rdy_pct = 100;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0; REQ_VALID = '0; REQ_LAST = '0; REQ_DATA = '0; UART_TXRDY = 1'b0;
    prev_grant = '0;

    // Single frame on req0
    do_reset();
    src_q[0] = {9'h041, 9'h042, 9'h143};
    run_drain("single", 200);
    exp_q = {'h41, 'h42, 'h43};
    chk_log("single_bytes", wen_log, exp_q);
    if (wen_cyc.size() == 3) begin
      chk("single_gap1", wen_cyc[1] - wen_cyc[0], SETTLE + 1);
      chk("single_gap2", wen_cyc[2] - wen_cyc[1], SETTLE + 1);
    end
    exp_q = {0};
    chk_log("single_grant", grant_log, exp_q);
    chk("single_busy_end", BUSY, 0);

    // Contention between req0 and req2, no interleaving
    do_reset();
    src_q[0] = {9'h0A1, 9'h1A2};
    src_q[2] = {9'h0C1, 9'h1C2};
    run_drain("contend", 200);
    exp_q = {'hA1, 'hA2, 'hC1, 'hC2};
    chk_log("contend_bytes", wen_log, exp_q);
    exp_q = {0, 2};
    chk_log("contend_grant", grant_log, exp_q);

    // Fairness: everyone always requesting
    do_reset();
    for (int i = 0; i < NREQ; i++)
      src_q[i] = {9'(8'h10 * i + 1), 9'(9'h100 + 8'h10 * i + 2), 9'(9'h100 + 8'h10 * i + 3)};
    run_drain("fair", 400);
    exp_q = {0, 1, 2, 0, 1, 2};
    chk_log("fair_grant", grant_log, exp_q);

    // Backpressure: TXRDY low for 50 cycles mid-frame is not a stall
    do_reset();
    src_q[0] = {9'h051, 9'h052, 9'h053, 9'h154};
    run_until_wen("bp", 2, 100);
    rdy_pct = 0;
    repeat (50) begin
      step();
      chk("bp_ready", REQ_READY, 0);
    end
    chk("bp_no_wen", wen_log.size(), 2);
    chk("bp_no_timeout", tout_cyc.size(), 0);
    rdy_pct = 100;
    run_drain("bp", 200);
    exp_q = {'h51, 'h52, 'h53, 'h54};
    chk_log("bp_bytes", wen_log, exp_q);

    // Stall timeout on req1, then req2 is served
    do_reset();
    src_q[1] = {9'h055};
    src_q[2] = {9'h166};
    run_drain("stall", 300);
    exp_q = {1, 2};
    chk_log("stall_grant", grant_log, exp_q);
    exp_q = {'h55, 'h66};
    chk_log("stall_bytes", wen_log, exp_q);
    chk("stall_pulses", tout_cyc.size(), 1);
    if (tout_cyc.size() == 1 && wen_cyc.size() >= 1)
      chk("stall_when", tout_cyc[0], wen_cyc[0] + SETTLE + STO);

    // Reset mid-frame: frame abandoned, pointer back to requester 0
    do_reset();
    src_q[0] = {9'h111};
    src_q[1] = {9'h021, 9'h022, 9'h023, 9'h124};
    run_until_wen("midrst", 3, 200);
    chk("midrst_owner", GRANT, 3'b010);
    do_reset();
    src_q[0] = {9'h131}; src_q[1] = {9'h132}; src_q[2] = {9'h133};
    run_drain("midrst", 200);
    exp_q = {0, 1, 2};
    chk_log("midrst_grant", grant_log, exp_q);
    exp_q = {'h31, 'h32, 'h33};
    chk_log("midrst_bytes", wen_log, exp_q);

    // Random traffic: frames, TXRDY throttling, valid drops and long holds
    do_reset();
    drop_pct = 10;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) rdy_pct = $urandom_range(30, 100);
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() < 4 && $urandom_range(99) < 8) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) src_q[i].push_back({1'(b == len - 1), 8'($urandom)});
        end
        if (hold_cnt[i] == 0 && $urandom_range(199) == 0) hold_cnt[i] = $urandom_range(5, 30);
      end
      step();
    end
    drop_pct = 0; rdy_pct = 100;
    for (int i = 0; i < NREQ; i++) hold_cnt[i] = 0;
    run_drain("random", 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
